// File: rtl/rf_wport_arbiter_if.sv
// Bundle of pipeline-side signals for the register-file write-port arbiter:
// WB request, LT handshake, issue/ID hazard query and reg_file write port.
interface rf_wport_arbiter_if;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        lt_valid;
  logic        lt_ready;
  logic [4:0]  lt_rd;
  logic [31:0] lt_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  id_rd;
  logic        id_stall;
  logic        lt_starve;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  // Pipeline / test side
  modport master (
    output wb_wen, wb_rd, wb_wdata,
    output lt_valid, lt_rd, lt_wdata,
    output iss_valid, iss_rd, rs, rt, id_rd,
    input  lt_ready, id_stall, lt_starve,
    input  rf_wen, rf_rd, rf_wdata
  );

  // Arbiter side
  modport slave (
    input  wb_wen, wb_rd, wb_wdata,
    input  lt_valid, lt_rd, lt_wdata,
    input  iss_valid, iss_rd, rs, rt, id_rd,
    output lt_ready, id_stall, lt_starve,
    output rf_wen, rf_rd, rf_wdata
  );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, LT results are
// buffered in a small FIFO and drain into idle port cycles. A pending
// scoreboard of outstanding LT destinations drives the ID-stage stall.
module rf_wport_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  rf_wport_arbiter_if.slave bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pend_q, pend_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          lt_starve_q, lt_starve_d;

  logic        wb_live;
  logic        fifo_empty;
  logic        fifo_full;
  logic        lt_ready;
  logic        push;
  logic        pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  // Handshake and arbitration decisions from registered FIFO state
  always_comb begin
    wb_live    = bus.wb_wen && (bus.wb_rd != '0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    lt_ready   = rst_n && !fifo_full;
    // Accepted writes to r0 are consumed by the handshake but never stored
    push       = bus.lt_valid && lt_ready && (bus.lt_rd != '0);
    pop        = rst_n && !wb_live && !fifo_empty;
    head_rd    = fifo_rd_q[rptr_q];
    head_data  = fifo_data_q[rptr_q];
  end

  // Write-port mux: WB first, else FIFO head, else idle
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_rd    = '0;
    bus.rf_wdata = '0;
    if (rst_n) begin
      if (wb_live) begin
        bus.rf_wen   = 1'b1;
        bus.rf_rd    = bus.wb_rd;
        bus.rf_wdata = bus.wb_wdata;
      end else if (!fifo_empty) begin
        bus.rf_wen   = 1'b1;
        bus.rf_rd    = head_rd;
        bus.rf_wdata = head_data;
      end
    end
  end

  // Next-state for pointers, occupancy, scoreboard and starvation tracking
  always_comb begin
    rptr_d       = rptr_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    pend_d       = pend_q;
    starve_cnt_d = starve_cnt_q;

    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear before set so a same-cycle issue to the drained register wins
    if (pop) pend_d[head_rd] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) pend_d[bus.iss_rd] = 1'b1;
    pend_d[0] = 1'b0;

    if (fifo_empty || pop)
      starve_cnt_d = '0;
    else if (wb_live && (starve_cnt_q != SMAX_C))
      starve_cnt_d = starve_cnt_q + SW'(1);

    lt_starve_d = (starve_cnt_d == SMAX_C);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      pend_q       <= '0;
      starve_cnt_q <= '0;
      lt_starve_q  <= 1'b0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      starve_cnt_q <= starve_cnt_d;
      lt_starve_q  <= lt_starve_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= bus.lt_rd;
      fifo_data_q[wptr_q] <= bus.lt_wdata;
    end
  end

  // Hazard stall from registered state only; held high through reset
  always_comb begin
    bus.lt_ready  = lt_ready;
    bus.lt_starve = lt_starve_q;
    bus.id_stall  = !rst_n || pend_q[bus.rs] || pend_q[bus.rt] ||
                    pend_q[bus.id_rd] || lt_starve_q;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  rf_wport_arbiter_if bus ();

  rf_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven after this
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.wb_wen    = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_wdata  = '0;
    bus.lt_valid  = 1'b0;
    bus.lt_rd     = '0;
    bus.lt_wdata  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.id_rd     = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset with every input active
    rst_n         = 1'b0;
    bus.wb_wen    = 1'b1;
    bus.wb_rd     = 5'd3;
    bus.wb_wdata  = 32'h1111_1111;
    bus.lt_valid  = 1'b1;
    bus.lt_rd     = 5'd6;
    bus.lt_wdata  = 32'h2222_2222;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    bus.rs        = 5'd5;
    bus.rt        = 5'd6;
    bus.id_rd     = 5'd7;
    cyc();
    cyc();
    settle();
    check("rst_rf_wen", 32'(bus.rf_wen), 32'd0);
    check("rst_lt_ready", 32'(bus.lt_ready), 32'd0);
    check("rst_id_stall", 32'(bus.id_stall), 32'd1);
    check("rst_rf_rd", 32'(bus.rf_rd), 32'd0);

    rst_n = 1'b1;
    idle();
    bus.rs = 5'd5;
    bus.rt = 5'd6;
    bus.id_rd = 5'd7;
    settle();
    check("rel_lt_ready", 32'(bus.lt_ready), 32'd1);
    check("rel_id_stall", 32'(bus.id_stall), 32'd0);
    check("rel_lt_starve", 32'(bus.lt_starve), 32'd0);
    check("rel_rf_wen", 32'(bus.rf_wen), 32'd0);

    // LT basic: issue r5, result 3 cycles later
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    settle();
    cyc();
    idle();
    bus.rs = 5'd5;
    settle();
    check("lt_pend_stall", 32'(bus.id_stall), 32'd1);
    cyc();
    cyc();
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd5;
    bus.lt_wdata = 32'hDEAD_BEEF;
    settle();
    check("lt_ready_basic", 32'(bus.lt_ready), 32'd1);
    check("lt_no_same_cycle", 32'(bus.rf_wen), 32'd0);
    check("lt_stall_wait", 32'(bus.id_stall), 32'd1);
    cyc();
    bus.lt_valid = 1'b0;
    settle();
    check("lt_port_wen", 32'(bus.rf_wen), 32'd1);
    check("lt_port_rd", 32'(bus.rf_rd), 32'd5);
    check("lt_port_data", bus.rf_wdata, 32'hDEAD_BEEF);
    check("lt_stall_at_write", 32'(bus.id_stall), 32'd1);
    cyc();
    settle();
    check("lt_stall_clear", 32'(bus.id_stall), 32'd0);
    check("lt_port_idle", 32'(bus.rf_wen), 32'd0);
    check("lt_port_idle_rd", 32'(bus.rf_rd), 32'd0);

    // Conflict: WB wins, FIFO drains next idle cycle
    idle();
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd7;
    bus.lt_wdata = 32'h77;
    settle();
    cyc();
    idle();
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd3;
    bus.wb_wdata = 32'h33;
    settle();
    check("cf_wb_rd", 32'(bus.rf_rd), 32'd3);
    check("cf_wb_data", bus.rf_wdata, 32'h33);
    cyc();
    idle();
    settle();
    check("cf_fifo_rd", 32'(bus.rf_rd), 32'd7);
    check("cf_fifo_data", bus.rf_wdata, 32'h77);
    cyc();
    // WB to r0 leaves the slot to the FIFO
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd8;
    bus.lt_wdata = 32'h88;
    settle();
    cyc();
    idle();
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd0;
    bus.wb_wdata = 32'h99;
    settle();
    check("r0_fifo_wen", 32'(bus.rf_wen), 32'd1);
    check("r0_fifo_rd", 32'(bus.rf_rd), 32'd8);
    check("r0_fifo_data", bus.rf_wdata, 32'h88);
    cyc();
    idle();
    settle();
    check("r0_drained", 32'(bus.rf_wen), 32'd0);

    // Full / backpressure / starvation
    idle();
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd4;
    bus.wb_wdata = 32'h40;
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd10;
    bus.lt_wdata = 32'hA0;
    settle();
    check("full_rdy1", 32'(bus.lt_ready), 32'd1);
    cyc();
    bus.lt_rd    = 5'd11;
    bus.lt_wdata = 32'hA1;
    settle();
    check("full_rdy2", 32'(bus.lt_ready), 32'd1);
    cyc();
    bus.lt_rd    = 5'd12;
    bus.lt_wdata = 32'hA2;
    settle();
    check("full_not_ready", 32'(bus.lt_ready), 32'd0);
    cyc();
    settle();
    check("full_held", 32'(bus.lt_ready), 32'd0);
    check("starve_early", 32'(bus.lt_starve), 32'd0);
    cyc();
    settle();
    check("starve_at3", 32'(bus.lt_starve), 32'd0);
    cyc();
    // Bubble: WB idle this cycle
    bus.wb_wen = 1'b0;
    settle();
    check("starve_set", 32'(bus.lt_starve), 32'd1);
    check("starve_stall", 32'(bus.id_stall), 32'd1);
    check("bubble_rd", 32'(bus.rf_rd), 32'd10);
    check("bubble_data", bus.rf_wdata, 32'hA0);
    check("bubble_not_ready", 32'(bus.lt_ready), 32'd0);
    cyc();
    bus.wb_wen = 1'b1;
    settle();
    check("starve_clear", 32'(bus.lt_starve), 32'd0);
    check("starve_unstall", 32'(bus.id_stall), 32'd0);
    check("third_ready", 32'(bus.lt_ready), 32'd1);
    cyc();
    idle();
    settle();
    check("drain_rd11", 32'(bus.rf_rd), 32'd11);
    check("drain_d11", bus.rf_wdata, 32'hA1);
    cyc();
    settle();
    check("drain_rd12", 32'(bus.rf_rd), 32'd12);
    check("drain_d12", bus.rf_wdata, 32'hA2);
    cyc();
    settle();
    check("drain_empty", 32'(bus.rf_wen), 32'd0);

    // Same-cycle set and clear of r9: set wins
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd9;
    bus.lt_wdata = 32'h909;
    settle();
    cyc();
    idle();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd9;
    settle();
    check("sc_port_rd9", 32'(bus.rf_rd), 32'd9);
    cyc();
    idle();
    bus.rs = 5'd9;
    settle();
    check("sc_pend9_kept", 32'(bus.id_stall), 32'd1);
    bus.rs = 5'd0;
    bus.rt = 5'd9;
    settle();
    check("sc_pend9_rt", 32'(bus.id_stall), 32'd1);
    idle();

    // Push while popping at occupancy 1
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd13;
    bus.lt_wdata = 32'hD0;
    settle();
    cyc();
    bus.lt_rd    = 5'd14;
    bus.lt_wdata = 32'hD1;
    settle();
    check("pp_rd13", 32'(bus.rf_rd), 32'd13);
    check("pp_ready", 32'(bus.lt_ready), 32'd1);
    cyc();
    bus.lt_valid = 1'b0;
    settle();
    check("pp_rd14", 32'(bus.rf_rd), 32'd14);
    check("pp_d14", bus.rf_wdata, 32'hD1);
    cyc();
    settle();
    check("pp_empty", 32'(bus.rf_wen), 32'd0);

    // Pointer wrap across 10 entries streamed back to back
    for (int i = 0; i < 10; i++) begin
      bus.lt_valid = 1'b1;
      bus.lt_rd    = 5'(16 + i);
      bus.lt_wdata = 32'h1000 + 32'(i);
      settle();
      if (i > 0) begin
        check("wrap_rd", 32'(bus.rf_rd), 32'(16 + i - 1));
        check("wrap_data", bus.rf_wdata, 32'h1000 + 32'(i - 1));
      end
      cyc();
    end
    bus.lt_valid = 1'b0;
    settle();
    check("wrap_last_rd", 32'(bus.rf_rd), 32'd25);
    check("wrap_last_data", bus.rf_wdata, 32'h1009);
    cyc();
    settle();
    check("wrap_empty", 32'(bus.rf_wen), 32'd0);

    // Mid-operation reset with two entries buffered and r9 pending
    bus.wb_wen   = 1'b1;
    bus.wb_rd    = 5'd2;
    bus.wb_wdata = 32'h22;
    bus.lt_valid = 1'b1;
    bus.lt_rd    = 5'd20;
    bus.lt_wdata = 32'hE0;
    settle();
    cyc();
    bus.lt_rd    = 5'd21;
    bus.lt_wdata = 32'hE1;
    settle();
    cyc();
    settle();
    check("mr_full", 32'(bus.lt_ready), 32'd0);
    idle();
    rst_n = 1'b0;
    settle();
    check("mr_rst_wen", 32'(bus.rf_wen), 32'd0);
    check("mr_rst_stall", 32'(bus.id_stall), 32'd1);
    cyc();
    rst_n = 1'b1;
    bus.rs = 5'd9;
    settle();
    check("mr_no_wen", 32'(bus.rf_wen), 32'd0);
    check("mr_ready", 32'(bus.lt_ready), 32'd1);
    check("mr_pend_clr", 32'(bus.id_stall), 32'd0);
    cyc();
    settle();
    check("mr_no_wen2", 32'(bus.rf_wen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
